tech_cg_ctrl: RTL and testbench
===============================

# tech_cg_ctrl

Clock-gate enable controller and wake scheduler for the SoC's per-subsystem `tech_cg` cells. Each of `N_DOMAINS` subsystems requests its clock with a req/ack handshake. The block drives the matching clock-gate enable and grants wake-ups one domain at a time, round-robin, to limit simultaneous clock turn-on. Once a request drops, it holds the clock for a programmable number of cycles before gating it. It sits in the always-on clock/reset area, directly upstream of the `en` inputs of the clock-gate cells.

## Interface
- `N_DOMAINS`, 4: number of gated domains; range 1..16.
- `WAKE_CYCLES`, 4: cycles from enable rise to ack rise; range 1..255.
- `HOLD_CYCLES`, 8: idle cycles after req drop before gating; range 0..255.
- `clk` in 1: always-on clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_DOMAINS: per-domain clock request, level-sensitive, synchronous to `clk`.
- `cg_en` out N_DOMAINS: registered enable to the `en` input of the clock-gate cell of each domain.
- `ack` out N_DOMAINS: registered; high means the domain clock is running and stable.
- `busy` out 1: registered; high while a wake sequence is in progress.
- `force_on` in N_DOMAINS: present only with `CG_CTRL_FORCE_ON_EN`; see Configuration.

## Operation
- Per-domain FSM states: OFF, PEND, WAKING, ON, HOLD.
  - Outputs per state: `cg_en` = 1 in WAKING, ON and HOLD. `ack` = 1 in ON and HOLD.
- OFF:
  - `req`=1 → PEND.
  - If the scheduler is free and this domain wins the same edge, go directly OFF→WAKING.
- PEND:
  - `req`=0 → OFF; no grant is consumed.
  - Granted → WAKING.
- Scheduler:
  - One shared wake timer, 8 bits, loaded with `WAKE_CYCLES` at grant and decremented each edge.
  - Free when no domain is in WAKING, or when the WAKING domain completes on this edge. This allows back-to-back grants.
  - Round-robin pointer `last`: the winner is the first requesting domain (OFF with `req`=1, or PEND) searching upward from `last`+1, modulo N_DOMAINS. `last` updates to the winner.
  - Reset value of `last` is N_DOMAINS-1, so domain 0 has first priority.
- WAKING:
  - Timer reaches 1 → leave WAKING.
  - Exit target: ON if `req`=1, else HOLD with the hold counter loaded.
  - A wake is never aborted.
- ON: `req`=0 → HOLD, per-domain hold counter loaded with `HOLD_CYCLES`.
- HOLD:
  - `req`=1 → ON; `ack` stays high and there is no glitch on `cg_en`.
  - Otherwise the counter decrements; at 0 → OFF.
  - With `HOLD_CYCLES`=0, the transition is ON→OFF on the first edge with `req`=0.
- `busy` = 1 while any domain is in WAKING.
- Reset, asynchronous:
  - All FSMs go to OFF; all counters clear; `last` = N_DOMAINS-1.
  - `cg_en`, `ack` and `busy` are all 0 immediately on reset assertion, including in the middle of a wake.

## Timing
- `req` first sampled high at edge k with the scheduler free and the domain winning:
  - `cg_en` is high after edge k.
  - `ack` is high after edge k+WAKE_CYCLES.
- Next grant: may occur at edge k+WAKE_CYCLES, so with back-to-back grants `busy` stays high continuously.
- Request drop: `req` sampled low at edge m while ON → `cg_en` and `ack` fall after edge m+1+HOLD_CYCLES.
- Handshake rules:
  - The requester keeps `req` high until `ack` is high before relying on its clock.
  - The requester must not use its clock after dropping `req`.
  - `ack` falling confirms the domain is gated.
- Simultaneous requests on one edge: exactly one grant; the others wait in PEND and are served in round-robin order, each WAKE_CYCLES apart.

## Configuration
- `CG_CTRL_FORCE_ON_EN` defined:
  - Adds the `force_on` input.
  - `cg_en[i]` = FSM enable OR a registered copy of `force_on[i]`, so the enable rises one cycle after `force_on` is asserted.
  - `force_on` does not affect the FSMs, `ack`, `busy` or scheduling. Its purpose is debug and scan clock forcing.
- Macro undefined: no `force_on` port; `cg_en` is purely FSM-driven.

## Test plan
- Reset mid-wake:
  - Stimulus: `req[0]`=1, then assert `rst_n`=0 two cycles after grant.
  - Required: `cg_en`, `ack` and `busy` drop to 0 immediately.
  - After release with `req[0]` still 1: a fresh full wake of 4 cycles.
- Single wake/hold with defaults:
  - Stimulus: `req[2]` rises.
  - Required: `cg_en[2]` 1 cycle later, `ack[2]` 4 cycles after that.
  - Stimulus: drop `req[2]`.
  - Required: `cg_en[2]` and `ack[2]` fall 9 cycles after the first low sample.
- Simultaneous requests:
  - Stimulus: `req`=4'b1111 on the same edge from reset.
  - Required: grants in order 0,1,2,3; `ack` bits rise at +4, +8, +12, +16 cycles; `busy` high for 16 cycles without gaps.
- Re-request during HOLD:
  - Stimulus: `req[1]` drops for 3 cycles, then rises again.
  - Required: `ack[1]` and `cg_en[1]` never fall; no new wake sequence (`busy` stays 0).
- Withdrawal in PEND and HOLD_CYCLES=0:
  - Stimulus: `req[3]` pulses for 2 cycles while domain 0 is waking.
  - Required: domain 3 is never granted and `cg_en[3]` stays 0.
  - Stimulus: with HOLD_CYCLES=0, drop `req` in ON.
  - Required: gated after 1 edge.
- Force (`CG_CTRL_FORCE_ON_EN`):
  - Stimulus: `force_on[1]`=1 with `req`=0.
  - Required: `cg_en[1]`=1 after 1 cycle, `ack[1]`=0, `busy`=0.

Source files
------------

// File: rtl/tech_cg_ctrl.sv
// Clock-gate enable controller with a round-robin wake scheduler and per-domain hold timers.
// Optional feature: define CG_CTRL_FORCE_ON_EN to add the force_on debug/scan input.
module tech_cg_ctrl #(
    parameter int unsigned N_DOMAINS   = 4,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_DOMAINS-1:0] req,
`ifdef CG_CTRL_FORCE_ON_EN
    input  logic [N_DOMAINS-1:0] force_on,
`endif
    output logic [N_DOMAINS-1:0] cg_en,
    output logic [N_DOMAINS-1:0] ack,
    output logic                 busy
);
    localparam int unsigned LastW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [7:0] WakeLoad = 8'(WAKE_CYCLES);
    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES);
    localparam logic [LastW-1:0] LastRst = LastW'(N_DOMAINS - 1);

    typedef enum logic [2:0] {StOff, StPend, StWaking, StOn, StHold} state_e;

    state_e               state_q [N_DOMAINS];
    state_e               state_d [N_DOMAINS];
    logic [7:0]           hold_q  [N_DOMAINS];
    logic [7:0]           hold_d  [N_DOMAINS];
    logic [7:0]           timer_q, timer_d;
    logic [LastW-1:0]     last_q, last_d;
    logic [N_DOMAINS-1:0] cg_en_q, cg_en_d;
    logic [N_DOMAINS-1:0] ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [N_DOMAINS-1:0] cand, grant;
    logic                 waking_any, wake_done, sched_free, grant_any;

    // A domain in PEND whose req has dropped is not a candidate, so no grant is wasted on it.
    always_comb begin
        cand       = '0;
        waking_any = 1'b0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            cand[i] = req[i] && (state_q[i] == StOff || state_q[i] == StPend);
            if (state_q[i] == StWaking) waking_any = 1'b1;
        end
    end

    assign wake_done  = waking_any && (timer_q == 8'd1);
    assign sched_free = !waking_any || wake_done;

    always_comb begin
        logic [LastW:0]   sum;
        logic [LastW-1:0] idx;
        grant     = '0;
        grant_any = 1'b0;
        last_d    = last_q;
        sum       = '0;
        idx       = '0;
        if (sched_free) begin
            for (int off = 1; off <= int'(N_DOMAINS); off++) begin
                sum = {1'b0, last_q} + (LastW+1)'(off);
                if (sum >= (LastW+1)'(N_DOMAINS)) sum = sum - (LastW+1)'(N_DOMAINS);
                idx = sum[LastW-1:0];
                if (!grant_any && cand[idx]) begin
                    grant[idx] = 1'b1;
                    grant_any  = 1'b1;
                    last_d     = idx;
                end
            end
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (grant_any) begin
            timer_d = WakeLoad;
        end else if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_DOMAINS; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            unique case (state_q[i])
                StOff: begin
                    if (grant[i]) state_d[i] = StWaking;
                    else if (req[i]) state_d[i] = StPend;
                end
                StPend: begin
                    if (grant[i]) state_d[i] = StWaking;
                    else if (!req[i]) state_d[i] = StOff;
                end
                StWaking: begin
                    if (wake_done) begin
                        if (req[i]) begin
                            state_d[i] = StOn;
                        end else begin
                            state_d[i] = StHold;
                            hold_d[i]  = HoldLoad;
                        end
                    end
                end
                StOn: begin
                    if (!req[i]) begin
                        if (HOLD_CYCLES == 0) begin
                            state_d[i] = StOff;
                        end else begin
                            state_d[i] = StHold;
                            hold_d[i]  = HoldLoad;
                        end
                    end
                end
                StHold: begin
                    if (req[i]) state_d[i] = StOn;
                    else if (hold_q[i] == 8'd0) state_d[i] = StOff;
                    else hold_d[i] = hold_q[i] - 8'd1;
                end
                default: state_d[i] = StOff;
            endcase
        end
    end

    // Outputs are registered from the next state so the gate enable never sees decode glitches.
    always_comb begin
        cg_en_d = '0;
        ack_d   = '0;
        busy_d  = 1'b0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            cg_en_d[i] = (state_d[i] == StWaking) || (state_d[i] == StOn) ||
                         (state_d[i] == StHold);
            ack_d[i]   = (state_d[i] == StOn) || (state_d[i] == StHold);
            if (state_d[i] == StWaking) busy_d = 1'b1;
        end
`ifdef CG_CTRL_FORCE_ON_EN
        cg_en_d = cg_en_d | force_on;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DOMAINS; i++) begin
                state_q[i] <= StOff;
                hold_q[i]  <= '0;
            end
            timer_q <= '0;
            last_q  <= LastRst;
            cg_en_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_DOMAINS; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            timer_q <= timer_d;
            last_q  <= last_d;
            cg_en_q <= cg_en_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign cg_en = cg_en_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tech_cg_ctrl.sv
// Scoreboard bench for tech_cg_ctrl: expected output transitions are queued with their cycle,
// a negedge monitor pops one on every observed change of {cg_en, ack, busy}.
module tb_tech_cg_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req_h0;
    logic [3:0] force_on, force_h0;
    logic [3:0] cg_en, ack, cg_en_h0, ack_h0;
    logic       busy, busy_h0;

    typedef struct {
        int         cyc;
        logic [8:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic [8:0] prev = '0;
    int   c, d, e, g, k, r, x, y, z, a, b;

    tech_cg_ctrl #(.N_DOMAINS(4), .WAKE_CYCLES(4), .HOLD_CYCLES(8)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef CG_CTRL_FORCE_ON_EN
        .force_on(force_on),
`endif
        .cg_en   (cg_en),
        .ack     (ack),
        .busy    (busy)
    );

    tech_cg_ctrl #(.N_DOMAINS(4), .WAKE_CYCLES(4), .HOLD_CYCLES(0)) u_dut_h0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_h0),
`ifdef CG_CTRL_FORCE_ON_EN
        .force_on(force_h0),
`endif
        .cg_en   (cg_en_h0),
        .ack     (ack_h0),
        .busy    (busy_h0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [8:0] obs;
        ev_t ev;
        obs = {cg_en, ack, busy};
        if (mon_en && obs !== prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change cyc=%0d got=%03h (none expected)", cyc, obs);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || ev.val !== obs) begin
                    n_err++;
                    $display("FAIL transition got cyc=%0d val=%03h required cyc=%0d val=%03h",
                             cyc, obs, ev.cyc, ev.val);
                end
            end
        end
        prev = obs;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int cy, input logic [3:0] cg, input logic [3:0] ak, input logic bz);
        ev_t ev;
        ev.cyc = cy;
        ev.val = {cg, ak, bz};
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s got=%b required=%b", name, act, req_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_h0 = '0; force_on = '0; force_h0 = '0;
        tick(2);
        mon_en = 1'b1;
        tick(1);
        rst_n = 1'b1;

        // Reset in the middle of a wake, then a fresh full wake.
        tick(1);
        c = cyc; req = 4'b0001; g = c + 1;
        push(g, 4'b0001, 4'b0000, 1'b1);
        tick(3);
        push(g + 2, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_cg_en", cg_en, 4'b0000);
        check("rst_ack", ack, 4'b0000);
        check("rst_busy", {3'b000, busy}, 4'b0000);
        tick(1);
        rst_n = 1'b1; r = cyc;
        push(r + 1, 4'b0001, 4'b0000, 1'b1);
        push(r + 5, 4'b0001, 4'b0001, 1'b0);
        tick(8);

        // Single wake and hold on domain 2.
        c = cyc; req = 4'b0101;
        push(c + 1, 4'b0101, 4'b0001, 1'b1);
        push(c + 5, 4'b0101, 4'b0101, 1'b0);
        tick(6);
        d = cyc; req = 4'b0001;
        push(d + 10, 4'b0001, 4'b0001, 1'b0);
        tick(12);

        // Bring up domain 1, then re-request it during HOLD: no output may move.
        e = cyc; req = 4'b0011;
        push(e + 1, 4'b0011, 4'b0001, 1'b1);
        push(e + 5, 4'b0011, 4'b0011, 1'b0);
        tick(6);
        req = 4'b0001;
        tick(3);
        req = 4'b0011;
        tick(14);

        // All four request on the first edge after reset: round-robin 0,1,2,3.
        x = cyc;
        push(x, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1; req = 4'b1111; k = cyc + 1;
        push(k,      4'b0001, 4'b0000, 1'b1);
        push(k + 4,  4'b0011, 4'b0001, 1'b1);
        push(k + 8,  4'b0111, 4'b0011, 1'b1);
        push(k + 12, 4'b1111, 4'b0111, 1'b1);
        push(k + 16, 4'b1111, 4'b1111, 1'b0);
        tick(18);

        // Domain 3 withdraws while pending behind domain 0's wake.
        y = cyc;
        push(y, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0; req = '0;
        tick(1);
        rst_n = 1'b1; req = 4'b0001; k = cyc + 1;
        push(k,     4'b0001, 4'b0000, 1'b1);
        push(k + 4, 4'b0001, 4'b0001, 1'b0);
        tick(1);
        req = 4'b1001;
        tick(2);
        req = 4'b0001;
        tick(6);
        z = cyc; req = '0;
        push(z + 10, 4'b0000, 4'b0000, 1'b0);
        tick(12);

        // HOLD_CYCLES=0 instance: gated on the first edge with req low.
        a = cyc; req_h0 = 4'b0001;
        tick(4);
        check("h0_ack_before", ack_h0, 4'b0000);
        check("h0_cg_en_waking", cg_en_h0, 4'b0001);
        tick(1);
        check("h0_ack_on", ack_h0, 4'b0001);
        b = cyc; req_h0 = '0;
        #1;
        check("h0_cg_en_still_on", cg_en_h0, 4'b0001);
        tick(1);
        check("h0_cg_en_gated", cg_en_h0, 4'b0000);
        check("h0_ack_gated", ack_h0, 4'b0000);
        tick(2);

`ifdef CG_CTRL_FORCE_ON_EN
        c = cyc; force_on = 4'b0010;
        push(c + 1, 4'b0010, 4'b0000, 1'b0);
        tick(4);
        c = cyc; force_on = '0;
        push(c + 1, 4'b0000, 4'b0000, 1'b0);
        tick(3);
`endif

        while (exp_q.size() != 0) begin
            ev_t ev;
            ev = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_transition required cyc=%0d val=%03h", ev.cyc, ev.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
